// File: rtl/instruction_fetch_pkg.sv
// Shared CPU definitions for the fetch stage: FSM states, halt opcode and PC step.
package instruction_fetch_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    localparam logic [5:0]  HALT_OPCODE_DEFAULT = 6'b111111;
    localparam logic [31:0] PC_INCREMENT        = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK       = 32'hFFFF_FFFC;

endpackage

// File: rtl/instruction_fetch_pc_register.sv
// 32-bit program counter register with asynchronous active-low reset and load enable.
module pc_register #(
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VALUE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC sequencing, one-entry IR buffer with Ready/Valid
// handshake, redirect flush and halt-on-opcode.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic [31:0] IAddr,
    input  logic [31:0] IDataIn,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    input  logic        Ready,
    output logic        Valid,
    output logic [31:0] IR,
    output logic [31:0] IRPC,
    output logic [31:0] IRPC4,
    output logic        Halted,
    output logic [31:0] FetchCount
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         pc_load;
    logic [31:0]  ir_q, ir_d;
    logic [31:0]  irpc_q, irpc_d;
    logic         valid_q, valid_d;
    logic [31:0]  count_q, count_d;
    logic         fetch;

    pc_register #(
        .RESET_VALUE (RESET_PC)
    ) u_pc_register (
        .clk   (CLK),
        .rst_n (Reset),
        .load  (pc_load),
        .d     (pc_d),
        .q     (pc_q)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= RUN;
            ir_q    <= '0;
            irpc_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            irpc_q  <= irpc_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Redirect outranks fetch and halt; a stalled IR (Valid & !Ready) holds everything.
    always_comb begin
        fetch   = (state_q == RUN) && !Redirect && (!valid_q || Ready);
        state_d = state_q;
        pc_d    = pc_q;
        pc_load = 1'b0;
        ir_d    = ir_q;
        irpc_d  = irpc_q;
        valid_d = valid_q;
        count_d = count_q;

        if (Redirect) begin
            pc_d    = RedirectTarget & PC_ALIGN_MASK;
            pc_load = 1'b1;
            valid_d = 1'b0;
            state_d = RUN;
        end else if (fetch) begin
            ir_d    = IDataIn;
            irpc_d  = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + PC_INCREMENT;
            pc_load = 1'b1;
            count_d = count_q + 32'd1;
            if (IDataIn[31:26] == HALT_OPCODE) begin
                state_d = HALT;
            end
        end else if (valid_q && Ready) begin
            valid_d = 1'b0;
        end
    end

    assign IAddr      = pc_q;
    assign Valid      = valid_q;
    assign IR         = ir_q;
    assign IRPC       = irpc_q;
    assign IRPC4      = irpc_q + PC_INCREMENT;
    assign Halted     = (state_q == HALT);
    assign FetchCount = count_q;

endmodule
